// File: rtl/flappy_game_ctrl_if.sv
// Signal bundle between the flappy-bird game core and its neighbours (bird/RNG in, VGA/7-seg out).
// There is no backpressure: scroll_tick is a single-cycle strobe, and every other signal is a level that is valid every clk.
interface flappy_game_ctrl_if #(
  parameter int NUM_PIPES = 2,
  parameter int POS_W     = 10,
  parameter int SCORE_W   = 16
);
  logic                       jump_btn;
  logic                       pause_btn;
  logic                       rst_btn;
  logic [7:0]                 rand_in;
  logic [10:0]                bird_y;
  logic [1:0]                 status;
  logic                       pause;
  logic [SCORE_W-1:0]         score;
  logic [NUM_PIPES*POS_W-1:0] pipe_pos;
  logic [NUM_PIPES*8-1:0]     pipe_gap;
  logic                       sound_en;
  logic                       scroll_tick;

  modport master (
    output jump_btn, pause_btn, rst_btn, rand_in, bird_y,
    input  status, pause, score, pipe_pos, pipe_gap, sound_en, scroll_tick
  );

  modport slave (
    input  jump_btn, pause_btn, rst_btn, rand_in, bird_y,
    output status, pause, score, pipe_pos, pipe_gap, sound_en, scroll_tick
  );
endinterface

// File: rtl/flappy_game_ctrl.sv
// Game-control core: scrolling pipes, scoring with speed tiers, collision, pause and score sound.
// The FSM state is published directly on bus.status (0 OVER, 1 IDLE, 2 PLAY).
module flappy_game_ctrl #(
  parameter int NUM_PIPES  = 2,
  parameter int POS_W      = 10,
  parameter int SPAN       = 400,
  parameter int PRESCALE_W = 18,
  parameter int TIER1      = 10,
  parameter int TIER2      = 30,
  parameter int SCORE_W    = 16,
  parameter int GAP_INIT   = 125,
  parameter int GAP_OFF    = 50,
  parameter int GAP_H      = 100,
  parameter int X_R        = 784,
  parameter int PIPE_W     = 40,
  parameter int BIRD_XL    = 219,
  parameter int BIRD_XR    = 249,
  parameter int Y_REF      = 511,
  parameter int BIRD_HALF  = 15,
  parameter int SND_TICKS  = 64
) (
  input logic               clk,
  input logic               clr,
  flappy_game_ctrl_if.slave bus
);
  localparam int SND_W = $clog2(SND_TICKS + 1);
  localparam int CNT_W = $clog2(NUM_PIPES + 1);

  typedef enum logic [1:0] {
    ST_OVER = 2'd0,
    ST_IDLE = 2'd1,
    ST_PLAY = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   pause_q, pause_d;

  logic jump_q, pause_btn_q, rst_btn_q;
  logic jump_ev, pause_ev, rst_ev;

  logic [POS_W-1:0]      pos_q [NUM_PIPES];
  logic [7:0]            gap_q [NUM_PIPES];
  logic [SCORE_W-1:0]    score_q, score_next;
  logic [SCORE_W:0]      score_sum;
  logic [CNT_W-1:0]      n_recycle;
  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W:0]   presc_sum;
  logic [2:0]            step;
  logic                  tick_q;
  logic [SND_W-1:0]      snd_cnt_q;
  logic                  snd_en_q;

  logic                  advance, step_en, score_inc, snd_dec;
  logic signed [31:0]    cy;
  logic                  any_hit, collision;

  logic [NUM_PIPES*POS_W-1:0] pos_flat;
  logic [NUM_PIPES*8-1:0]     gap_flat;

  assign jump_ev  = bus.jump_btn  & ~jump_q;
  assign pause_ev = bus.pause_btn & ~pause_btn_q;
  assign rst_ev   = bus.rst_btn   & ~rst_btn_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      jump_q      <= 1'b0;
      pause_btn_q <= 1'b0;
      rst_btn_q   <= 1'b0;
    end else begin
      jump_q      <= bus.jump_btn;
      pause_btn_q <= bus.pause_btn;
      rst_btn_q   <= bus.rst_btn;
    end
  end

  // Bird box overlaps pipe i horizontally and sticks out of its gap opening.
  function automatic logic pipe_hit(input logic [POS_W-1:0] pos,
                                    input logic [7:0] gap,
                                    input logic signed [31:0] cy_in);
    logic signed [31:0] xl, top, bot;
    xl  = X_R - SPAN - signed'(32'(pos));
    top = signed'(32'(gap)) + GAP_OFF;
    bot = top + GAP_H;
    return (BIRD_XR > xl) && (BIRD_XL < xl + PIPE_W) &&
           ((cy_in - BIRD_HALF < top) || (cy_in + BIRD_HALF > bot));
  endfunction

  always_comb begin
    cy      = Y_REF - signed'(32'(bus.bird_y));
    any_hit = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      any_hit = any_hit | pipe_hit(pos_q[i], gap_q[i], cy);
    end
    collision = (state_q == ST_PLAY) && ((bus.bird_y == '0) || any_hit);
  end

  always_comb begin
    state_d = state_q;
    pause_d = pause_q;
    case (state_q)
      ST_PLAY: begin
        if (collision)     state_d = ST_OVER;
        else if (pause_ev) pause_d = ~pause_q;
      end
      ST_IDLE: if (jump_ev) state_d = ST_PLAY;
      ST_OVER: if (rst_ev)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d != ST_PLAY) pause_d = 1'b0;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      pause_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pause_q <= pause_d;
    end
  end

  always_comb begin
    if (score_q < SCORE_W'(TIER1))      step = 3'd1;
    else if (score_q < SCORE_W'(TIER2)) step = 3'd2;
    else                                step = 3'd4;
    presc_sum = {1'b0, presc_q} + (PRESCALE_W+1)'(step);

    n_recycle = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (pos_q[i] >= POS_W'(SPAN)) n_recycle = n_recycle + CNT_W'(1);
    end
    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(n_recycle);
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
  end

  // A tick registered on the last PLAY/unpaused cycle can surface after a pause or
  // collision; it then moves nothing, but in OVER it still counts down the sound.
  assign advance   = (state_q == ST_PLAY) && !pause_q;
  assign step_en   = tick_q && (state_q == ST_PLAY) && !pause_q;
  assign score_inc = step_en && (score_next != score_q);
  assign snd_dec   = tick_q && !pause_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_q[i] <= POS_W'(i * SPAN / NUM_PIPES);
        gap_q[i] <= 8'(GAP_INIT);
      end
      score_q   <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      snd_cnt_q <= '0;
      snd_en_q  <= 1'b0;
    end else if (state_q == ST_IDLE) begin
      for (int i = 0; i < NUM_PIPES; i++) begin
        pos_q[i] <= POS_W'(i * SPAN / NUM_PIPES);
        gap_q[i] <= 8'(GAP_INIT);
      end
      score_q   <= '0;
      presc_q   <= '0;
      tick_q    <= 1'b0;
      snd_cnt_q <= '0;
      snd_en_q  <= 1'b0;
    end else begin
      if (advance) presc_q <= presc_sum[PRESCALE_W-1:0];
      tick_q <= advance && presc_sum[PRESCALE_W];
      if (step_en) begin
        for (int i = 0; i < NUM_PIPES; i++) begin
          if (pos_q[i] >= POS_W'(SPAN)) begin
            pos_q[i] <= '0;
            gap_q[i] <= bus.rand_in;
          end else begin
            pos_q[i] <= pos_q[i] + POS_W'(1);
          end
        end
        score_q <= score_next;
      end
      if (score_inc) begin
        snd_cnt_q <= SND_W'(SND_TICKS);
        snd_en_q  <= 1'b1;
      end else if (snd_dec && (snd_cnt_q != '0)) begin
        snd_cnt_q <= snd_cnt_q - SND_W'(1);
        if (snd_cnt_q == SND_W'(1)) snd_en_q <= 1'b0;
      end
    end
  end

  always_comb begin
    pos_flat = '0;
    gap_flat = '0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      pos_flat[i*POS_W +: POS_W] = pos_q[i];
      gap_flat[i*8 +: 8]         = gap_q[i];
    end
  end

  assign bus.status      = state_q;
  assign bus.pause       = pause_q;
  assign bus.score       = score_q;
  assign bus.pipe_pos    = pos_flat;
  assign bus.pipe_gap    = gap_flat;
  assign bus.sound_en    = snd_en_q;
  assign bus.scroll_tick = tick_q;
endmodule
